// File: rtl/nn_host_cmd_engine.sv
// Host-pin command responder: decodes strobed byte commands from the TinyTapeout pins
// into single-cycle core strobes and returns result bytes over the bidirectional uio bus.
module nn_host_cmd_engine #(
    parameter int RD_LATENCY   = 1,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       core_wr_en,
    output logic       core_wr_sel,
    output logic [3:0] core_wr_addr,
    output logic [7:0] core_wr_data,
    output logic       core_start,
    output logic [3:0] core_rd_addr,
    input  logic [7:0] core_rd_data,
    input  logic       core_busy,
    input  logic       core_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RDWAIT,
        S_DRIVE
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WR_W   = 3'd1;
    localparam logic [2:0] OP_WR_X   = 3'd2;
    localparam logic [2:0] OP_START  = 3'd3;
    localparam logic [2:0] OP_READ   = 3'd4;
    localparam logic [2:0] OP_STATUS = 3'd5;
    localparam logic [2:0] OP_CLEAR  = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    state_t     r_state;
    logic       r_strb_q;
    logic       r_armed;
    logic [2:0] r_op;
    logic [3:0] r_addr;
    logic [7:0] r_data;
    logic       r_ack;
    logic       r_err;
    logic       r_done;
    logic       r_wr_en;
    logic       r_wr_sel;
    logic       r_start;
    logic [3:0] r_rd_addr;
    logic [7:0] r_rd_byte;
    logic       r_oe;
    logic [1:0] r_rd_cnt;
    logic [7:0] r_tmo_cnt;
    logic       r_tmo_act;

    logic w_idle;
    logic w_exec;
    logic w_rise;
    logic w_accept;
    logic w_op_wr;
    logic w_start_go;
    logic w_tmo_fire;
    logic w_err_set;
    logic w_err_clr;
    logic w_done_clr;

    // r_armed keeps a strobe that was already high through reset from being taken as a new command.
    always_comb begin
        w_idle     = (r_state == S_IDLE);
        w_exec     = (r_state == S_EXEC);
        w_rise     = ui_in[7] & ~r_strb_q & r_armed;
        w_accept   = w_rise & w_idle;
        w_op_wr    = (r_op == OP_WR_W) || (r_op == OP_WR_X);
        w_start_go = w_exec && (r_op == OP_START) && !core_busy;
        w_tmo_fire = r_tmo_act && core_busy && !core_done && (r_tmo_cnt == 8'd0);
        w_err_clr  = w_exec && (r_op == OP_CLEAR);
        w_done_clr = w_err_clr || w_start_go;
        w_err_set  = (w_rise && !w_idle) || w_tmo_fire
                   || (w_exec && core_busy && (w_op_wr || (r_op == OP_START)))
                   || (w_exec && (r_op == OP_RSVD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_strb_q  <= 1'b0;
            r_armed   <= 1'b0;
            r_op      <= 3'd0;
            r_addr    <= 4'd0;
            r_data    <= 8'd0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_sel  <= 1'b0;
            r_start   <= 1'b0;
            r_rd_addr <= 4'd0;
            r_rd_byte <= 8'd0;
            r_oe      <= 1'b0;
            r_rd_cnt  <= 2'd0;
            r_tmo_cnt <= 8'd0;
            r_tmo_act <= 1'b0;
        end else begin
            r_strb_q <= ui_in[7];
            r_armed  <= r_armed | ~ui_in[7];
            r_wr_en  <= 1'b0;
            r_start  <= 1'b0;

            if (w_err_clr)
                r_err <= 1'b0;
            else if (w_err_set)
                r_err <= 1'b1;

            if (w_done_clr)
                r_done <= 1'b0;
            else if (core_done)
                r_done <= 1'b1;

            // Watchdog only counts cycles the core reports busy; it disarms itself after firing once.
            if (w_start_go) begin
                r_tmo_cnt <= 8'(BUSY_TIMEOUT);
                r_tmo_act <= 1'b1;
            end else if (r_tmo_act) begin
                if (core_done)
                    r_tmo_act <= 1'b0;
                else if (core_busy) begin
                    if (r_tmo_cnt != 8'd0)
                        r_tmo_cnt <= r_tmo_cnt - 8'd1;
                    else
                        r_tmo_act <= 1'b0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= ui_in[6:4];
                        r_addr  <= ui_in[3:0];
                        r_data  <= uio_in;
                        // Presenting the read address at accept gives the core a full RD_LATENCY window.
                        if (ui_in[6:4] == OP_READ)
                            r_rd_addr <= ui_in[3:0];
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_ack   <= ~r_ack;
                    r_state <= S_IDLE;
                    case (r_op)
                        OP_WR_W, OP_WR_X: begin
                            if (!core_busy) begin
                                r_wr_en  <= 1'b1;
                                r_wr_sel <= r_op[1];
                            end
                        end
                        OP_START: begin
                            if (!core_busy)
                                r_start <= 1'b1;
                        end
                        OP_READ: begin
                            r_ack    <= r_ack;
                            r_rd_cnt <= 2'(RD_LATENCY - 1);
                            r_state  <= S_RDWAIT;
                        end
                        OP_NOP, OP_STATUS, OP_CLEAR, OP_RSVD: ;
                        default: ;
                    endcase
                end
                S_RDWAIT: begin
                    if (r_rd_cnt == 2'd0) begin
                        r_rd_byte <= core_rd_data;
                        r_oe      <= 1'b1;
                        r_ack     <= ~r_ack;
                        r_state   <= S_DRIVE;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 2'd1;
                    end
                end
                S_DRIVE: begin
                    if (!r_strb_q) begin
                        r_oe    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign uo_out       = {r_ack, core_busy | ~w_idle, r_done, r_err, r_addr};
    assign uio_out      = r_rd_byte;
    assign uio_oe       = {8{r_oe}};
    assign core_wr_en   = r_wr_en;
    assign core_wr_sel  = r_wr_sel;
    assign core_wr_addr = r_addr;
    assign core_wr_data = r_data;
    assign core_start   = r_start;
    assign core_rd_addr = r_rd_addr;

endmodule

// File: tb/tb_nn_host_cmd_engine.sv
// Directed bench for nn_host_cmd_engine with a two-stage registered result memory model.
module tb_nn_host_cmd_engine;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       core_wr_en;
    logic       core_wr_sel;
    logic [3:0] core_wr_addr;
    logic [7:0] core_wr_data;
    logic       core_start;
    logic [3:0] core_rd_addr;
    logic [7:0] core_rd_data;
    logic       core_busy;
    logic       core_done;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int start_cnt = 0;

    logic [7:0] pipe0;
    logic [7:0] pipe1;

    nn_host_cmd_engine #(
        .RD_LATENCY  (2),
        .BUSY_TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ui_in       (ui_in),
        .uio_in      (uio_in),
        .uo_out      (uo_out),
        .uio_out     (uio_out),
        .uio_oe      (uio_oe),
        .core_wr_en  (core_wr_en),
        .core_wr_sel (core_wr_sel),
        .core_wr_addr(core_wr_addr),
        .core_wr_data(core_wr_data),
        .core_start  (core_start),
        .core_rd_addr(core_rd_addr),
        .core_rd_data(core_rd_data),
        .core_busy   (core_busy),
        .core_done   (core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [3:0] a);
        return (a == 4'd3) ? 8'h7E : (8'h10 + {4'd0, a});
    endfunction

    always @(posedge clk) begin
        pipe0 <= mem_val(core_rd_addr);
        pipe1 <= pipe0;
    end
    assign core_rd_data = pipe1;

    always @(posedge clk) begin
        if (core_wr_en === 1'b1) wr_cnt++;
        if (core_start === 1'b1) start_cnt++;
    end

    task automatic send_cmd(input logic [7:0] ui, input logic [7:0] d);
        @(negedge clk);
        ui_in  = ui;
        uio_in = d;
        @(negedge clk);
        @(negedge clk);
        ui_in = ui & 8'h7F;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ui_in = 8'h9A; uio_in = 8'h5C; core_busy = 1'b0; core_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL reset_uo_out got=%h exp=00", uo_out); end
        checks++; if (uio_oe !== 8'h00) begin failures++; $display("FAIL reset_uio_oe got=%h exp=00", uio_oe); end
        checks++; if (uio_out !== 8'h00) begin failures++; $display("FAIL reset_uio_out got=%h exp=00", uio_out); end
        checks++; if ({core_wr_en, core_start, core_rd_addr} !== 6'd0) begin failures++; $display("FAIL reset_core got=%b exp=0", {core_wr_en, core_start, core_rd_addr}); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (wr_cnt !== 0) begin failures++; $display("FAIL reset_no_accept wr_cnt=%0d exp=0", wr_cnt); end
        checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL reset_held_strobe uo_out=%h exp=00", uo_out); end
        ui_in = 8'h1A;
        @(negedge clk);
    endtask

    task automatic test_write;
        int w0;
        w0 = wr_cnt;
        @(negedge clk); ui_in = 8'h9A; uio_in = 8'h5C;
        @(negedge clk);
        checks++; if (uo_out[6] !== 1'b1) begin failures++; $display("FAIL wr_busy_flag got=%b exp=1", uo_out[6]); end
        checks++; if (uo_out[3:0] !== 4'hA) begin failures++; $display("FAIL wr_last_addr got=%h exp=a", uo_out[3:0]); end
        @(negedge clk);
        checks++; if (core_wr_en !== 1'b1) begin failures++; $display("FAIL wr_w_en got=%b exp=1", core_wr_en); end
        checks++; if ({core_wr_sel, core_wr_addr, core_wr_data} !== {1'b0, 4'hA, 8'h5C}) begin failures++; $display("FAIL wr_w_fields got=%b/%h/%h exp=0/a/5c", core_wr_sel, core_wr_addr, core_wr_data); end
        checks++; if (uo_out[7] !== 1'b1) begin failures++; $display("FAIL wr_w_ack got=%b exp=1", uo_out[7]); end
        ui_in = 8'h1A;
        @(negedge clk);
        checks++; if (core_wr_en !== 1'b0 || wr_cnt - w0 !== 1) begin failures++; $display("FAIL wr_w_single en=%b pulses=%0d exp=0/1", core_wr_en, wr_cnt - w0); end
        send_cmd(8'hA5, 8'h33);
        checks++; if ({core_wr_en, core_wr_sel, core_wr_addr, core_wr_data} !== {1'b1, 1'b1, 4'h5, 8'h33}) begin failures++; $display("FAIL wr_x_fields got=%b/%b/%h/%h exp=1/1/5/33", core_wr_en, core_wr_sel, core_wr_addr, core_wr_data); end
        checks++; if (uo_out[7] !== 1'b0) begin failures++; $display("FAIL wr_x_ack got=%b exp=0", uo_out[7]); end
    endtask

    task automatic test_read;
        logic a0;
        a0 = uo_out[7];
        @(negedge clk); ui_in = 8'hC3;
        @(negedge clk);
        checks++; if (core_rd_addr !== 4'h3) begin failures++; $display("FAIL rd_addr got=%h exp=3", core_rd_addr); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (uio_oe !== 8'h00 || uo_out[7] !== a0) begin failures++; $display("FAIL rd_early oe=%h ack=%b exp=00/%b", uio_oe, uo_out[7], a0); end
        @(negedge clk);
        checks++; if (uio_out !== 8'h7E || uio_oe !== 8'hFF) begin failures++; $display("FAIL rd_data got=%h oe=%h exp=7e/ff", uio_out, uio_oe); end
        checks++; if (uo_out[7] !== ~a0) begin failures++; $display("FAIL rd_ack got=%b exp=%b", uo_out[7], ~a0); end
        ui_in = 8'h43;
        @(negedge clk);
        checks++; if (uio_oe !== 8'hFF) begin failures++; $display("FAIL rd_hold_oe got=%h exp=ff", uio_oe); end
        @(negedge clk);
        checks++; if (uio_oe !== 8'h00 || uo_out[6] !== 1'b0) begin failures++; $display("FAIL rd_release oe=%h busy=%b exp=00/0", uio_oe, uo_out[6]); end
    endtask

    task automatic test_start_busy;
        int s0;
        s0 = start_cnt;
        send_cmd(8'hB0, 8'h00);
        checks++; if (core_start !== 1'b1 || uo_out[4] !== 1'b0) begin failures++; $display("FAIL start_pulse start=%b err=%b exp=1/0", core_start, uo_out[4]); end
        core_busy = 1'b1;
        send_cmd(8'hB0, 8'h00);
        checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL start_single pulses=%0d exp=1", start_cnt - s0); end
        checks++; if (uo_out[5:4] !== 2'b01) begin failures++; $display("FAIL start_busy_err done_err=%b exp=01", uo_out[5:4]); end
        core_done = 1'b1; core_busy = 1'b0;
        @(negedge clk);
        core_done = 1'b0;
        checks++; if (uo_out[5:4] !== 2'b11) begin failures++; $display("FAIL done_sticky done_err=%b exp=11", uo_out[5:4]); end
        send_cmd(8'hE0, 8'h00);
        checks++; if (uo_out[5:4] !== 2'b00) begin failures++; $display("FAIL clear done_err=%b exp=00", uo_out[5:4]); end
    endtask

    task automatic test_timeout;
        send_cmd(8'hB0, 8'h00);
        checks++; if (core_start !== 1'b1) begin failures++; $display("FAIL tmo_start got=%b exp=1", core_start); end
        core_busy = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (uo_out[4] !== 1'b0 || uo_out[6] !== 1'b1) begin failures++; $display("FAIL tmo_early err=%b busy=%b exp=0/1", uo_out[4], uo_out[6]); end
        @(negedge clk);
        checks++; if (uo_out[4] !== 1'b1) begin failures++; $display("FAIL tmo_fire err=%b exp=1", uo_out[4]); end
        send_cmd(8'hE0, 8'h00);
        checks++; if (uo_out[4] !== 1'b0) begin failures++; $display("FAIL tmo_clear err=%b exp=0", uo_out[4]); end
        repeat (6) @(negedge clk);
        checks++; if (uo_out[4] !== 1'b0) begin failures++; $display("FAIL tmo_once err=%b exp=0", uo_out[4]); end
        core_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_err_rdwait;
        logic a0;
        int   w0;
        a0 = uo_out[7];
        send_cmd(8'hF0, 8'h00);
        checks++; if (uo_out[4] !== 1'b1 || uo_out[7] !== ~a0) begin failures++; $display("FAIL rsvd_op err=%b ack=%b exp=1/%b", uo_out[4], uo_out[7], ~a0); end
        send_cmd(8'hE0, 8'h00);
        checks++; if (uo_out[4] !== 1'b0) begin failures++; $display("FAIL rsvd_clear err=%b exp=0", uo_out[4]); end
        a0 = uo_out[7];
        w0 = wr_cnt;
        @(negedge clk); ui_in = 8'hC6;
        @(negedge clk); ui_in = 8'h46;
        @(negedge clk); ui_in = 8'h9A; uio_in = 8'h11;
        @(negedge clk);
        checks++; if (uo_out[4] !== 1'b1 || uo_out[6] !== 1'b1 || uio_oe !== 8'h00) begin failures++; $display("FAIL rdwait_edge err=%b busy=%b oe=%h exp=1/1/00", uo_out[4], uo_out[6], uio_oe); end
        @(negedge clk);
        checks++; if (uio_out !== 8'h16 || uio_oe !== 8'hFF || uo_out[7] !== ~a0) begin failures++; $display("FAIL rdwait_data got=%h oe=%h ack=%b exp=16/ff/%b", uio_out, uio_oe, uo_out[7], ~a0); end
        checks++; if (uo_out[3:0] !== 4'h6 || wr_cnt !== w0) begin failures++; $display("FAIL rdwait_ignored addr=%h wr=%0d exp=6/%0d", uo_out[3:0], wr_cnt, w0); end
        ui_in = 8'h1A;
        repeat (2) @(negedge clk);
        checks++; if (uio_oe !== 8'h00 || uo_out[6] !== 1'b0 || uo_out[4] !== 1'b1) begin failures++; $display("FAIL rdwait_exit oe=%h busy=%b err=%b exp=00/0/1", uio_oe, uo_out[6], uo_out[4]); end
    endtask

    task automatic test_async_reset;
        @(negedge clk); ui_in = 8'hC3;
        repeat (4) @(negedge clk);
        checks++; if (uio_oe !== 8'hFF) begin failures++; $display("FAIL arst_pre_oe got=%h exp=ff", uio_oe); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (uio_oe !== 8'h00 || uo_out !== 8'h00) begin failures++; $display("FAIL arst_release oe=%h uo=%h exp=00/00", uio_oe, uo_out); end
        ui_in = 8'h00;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_start_busy();
        test_timeout();
        test_err_rdwait();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time_limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
